// File: rtl/traffic_sensor_cond_if.sv
// Sensor-to-controller signal bundle for traffic_sensor_cond.
// The master side drives the raw road sensors. The slave side (the
// conditioning block) returns the clean traffic-present levels.
interface traffic_sensor_cond_if;
    logic sa_raw;   // raw road-A sensor, asynchronous
    logic sb_raw;   // raw road-B sensor, asynchronous
    logic ta;       // conditioned road-A traffic present
    logic tb;       // conditioned road-B traffic present

    modport master (output sa_raw, output sb_raw, input ta, input tb);
    modport slave  (input sa_raw, input sb_raw, output ta, output tb);
endinterface

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: conditions the two raw road sensors for the
// traffic-light controller. Each channel works independently and runs a
// 2-flop synchronizer, then a debounce FSM, then an optional stretch after
// the debounced drop.
//
// Optional feature macro: SENSOR_STRETCH_EN.
//   Defined   : adds a HOLD state, so a debounced drop stays high for
//               STRETCH more cycles.
//   Undefined : uses four states, and FALL_CHK completion returns to IDLE.
module traffic_sensor_cond #(
    parameter int DEBOUNCE = 4,   // identical samples needed to change output (2..15)
    parameter int STRETCH  = 8,   // hold cycles after debounced drop (1..15)
    parameter int CNT_W    = 4    // per-channel counter width
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_sensor_cond_if.slave   sens
);

    localparam int NCH = 2;   // channel 0 = road A, channel 1 = road B

    // Elaboration-time legality checks on the configuration.
    if (DEBOUNCE < 2 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("traffic_sensor_cond: DEBOUNCE out of range 2..15");
    end
    if (STRETCH < 1 || STRETCH > 15) begin : g_bad_stretch
        $error("traffic_sensor_cond: STRETCH out of range 1..15");
    end
    if ((2 ** CNT_W) - 1 < DEBOUNCE) begin : g_bad_cnt_w_deb
        $error("traffic_sensor_cond: CNT_W too narrow for DEBOUNCE");
    end
`ifdef SENSOR_STRETCH_EN
    if ((2 ** CNT_W) - 1 < STRETCH) begin : g_bad_cnt_w_str
        $error("traffic_sensor_cond: CNT_W too narrow for STRETCH");
    end
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
`ifdef SENSOR_STRETCH_EN
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH - 1);
`endif

`ifdef SENSOR_STRETCH_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RISE_CHK = 3'd1,
        ACTIVE   = 3'd2,
        FALL_CHK = 3'd3,
        HOLD     = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISE_CHK = 2'd1,
        ACTIVE   = 2'd2,
        FALL_CHK = 2'd3
    } state_t;
`endif

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q, s1_d;
    logic [NCH-1:0]   s2_q, s2_d;
    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   present;

    assign raw = {sens.sb_raw, sens.sa_raw};

    // Synchronizer next values: raw goes into s1, and s1 goes into s2.
    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
    end

    // State register for the synchronizers, debounce FSMs and counters.
    // NOTE: the reset is asynchronous and clears every flop, including the
    // first synchronizer stage, so asserting reset drops the outputs without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            s1_q <= s1_d;
            s2_q <= s2_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-channel next-state and counter logic. s2 is tested before the
    // counter, so a sample returning to its old level on the completing
    // edge cancels the change.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            // NOTE: defaults come first, so no path can infer a latch.
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (s2_q[i]) begin
                        state_d[i] = RISE_CHK;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                RISE_CHK: begin
                    if (!s2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = ACTIVE;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (!s2_q[i]) begin
                        state_d[i] = FALL_CHK;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                FALL_CHK: begin
                    if (s2_q[i]) begin
                        state_d[i] = ACTIVE;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == DEB_LAST) begin
`ifdef SENSOR_STRETCH_EN
                        state_d[i] = HOLD;
`else
                        state_d[i] = IDLE;
`endif
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
`ifdef SENSOR_STRETCH_EN
                HOLD: begin
                    if (s2_q[i]) begin
                        state_d[i] = ACTIVE;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == STR_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Traffic-present decode straight from the state register (glitch-free).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            present[i] = (state_q[i] != IDLE) && (state_q[i] != RISE_CHK);
        end
    end

    assign sens.ta = present[0];
    assign sens.tb = present[1];

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Self-checking bench for traffic_sensor_cond (DEBOUNCE=4, STRETCH=8).
// Each cycle pushes its expected output levels when the stimulus is driven.
// The cycle then pops those levels and compares them one time unit after
// the rising edge. Expected timing comes from the edge-numbered latencies:
// an output changes after edge DEBOUNCE+1, or after edge DEBOUNCE+1+STRETCH
// for a stretched drop.
module tb_traffic_sensor_cond;

    localparam int DEBOUNCE = 4;
    localparam int STRETCH  = 8;
    localparam int CNT_W    = 4;

    localparam int RISE_EDGE = DEBOUNCE + 1;            // output rises after this edge
`ifdef SENSOR_STRETCH_EN
    localparam int FALL_EDGE = DEBOUNCE + 1 + STRETCH;  // output falls after this edge
`else
    localparam int FALL_EDGE = DEBOUNCE + 1;
`endif

    typedef struct {
        string name;
        bit    ta;
        bit    tb;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    traffic_sensor_cond_if sens ();

    traffic_sensor_cond #(
        .DEBOUNCE (DEBOUNCE),
        .STRETCH  (STRETCH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sens  (sens)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the expected levels for the coming edge. Then wait for the edge,
    // pop the entry and compare.
    task automatic cycle(input string nm, input bit exp_ta, input bit exp_tb);
        exp_t e;
        e.name = nm;
        e.ta   = exp_ta;
        e.tb   = exp_tb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty at time %0t", nm, $time);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (sens.ta !== e.ta || sens.tb !== e.tb) begin
                errors++;
                $display("FAIL %s: ta/tb got %b/%b, expected %b/%b at time %0t",
                         e.name, sens.ta, sens.tb, e.ta, e.tb, $time);
            end
        end
    endtask

    // Drive a level on both inputs. Then run n edges, expecting both
    // outputs to rise after RISE_EDGE (rise=1) or fall after FALL_EDGE (rise=0).
    // An input marked "keep" holds its current output level.
    task automatic run_edges(input string nm, input int n,
                             input bit a_keep, input bit a_rise,
                             input bit b_keep, input bit b_hold_val, input bit b_rise);
        bit ea;
        bit eb;
        for (int k = 0; k < n; k++) begin
            if (a_keep) ea = 1'b1;
            else        ea = a_rise ? (k >= RISE_EDGE) : (k < FALL_EDGE);
            if (b_keep) eb = b_hold_val;
            else        eb = b_rise ? (k >= RISE_EDGE) : (k < FALL_EDGE);
            cycle(nm, ea, eb);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        sens.sa_raw = 1'b1;
        sens.sb_raw = 1'b1;
        #1;
        checks++;
        if (sens.ta !== 1'b0 || sens.tb !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: ta/tb got %b/%b, expected 0/0", sens.ta, sens.tb);
        end
        for (int k = 0; k < 4; k++) cycle("reset_hold", 1'b0, 1'b0);
        sens.sa_raw = 1'b0;
        sens.sb_raw = 1'b0;
        reset       = 1'b0;
        for (int k = 0; k < 4; k++) cycle("reset_release_idle", 1'b0, 1'b0);
    endtask

    task automatic test_assert();
        sens.sa_raw = 1'b1;
        for (int k = 0; k < 10; k++) cycle("clean_assert", k >= RISE_EDGE, 1'b0);
    endtask

    task automatic test_deassert();
        sens.sa_raw = 1'b0;
        for (int k = 0; k < FALL_EDGE + 4; k++) cycle("clean_deassert", k < FALL_EDGE, 1'b0);
    endtask

    task automatic test_glitch();
        // Three-edge pulse: one sample short of the debounce count.
        for (int k = 0; k < 20; k++) begin
            sens.sa_raw = (k < 3);
            cycle("glitch_3", 1'b0, 1'b0);
        end
        // Single-edge pulse.
        for (int k = 0; k < 20; k++) begin
            sens.sa_raw = (k < 1);
            cycle("glitch_1", 1'b0, 1'b0);
        end
    endtask

    // From ACTIVE, drop sa_raw for exactly DEBOUNCE-1 edges, then restore it.
    // The restored sample reaches the FSM on the edge where the fall count
    // would complete, so the output must never dip.
    task automatic test_cancel();
        sens.sa_raw = 1'b1;
        for (int k = 0; k < 8; k++) cycle("cancel_setup", k >= RISE_EDGE, 1'b0);
        for (int k = 0; k < 12; k++) begin
            sens.sa_raw = !(k < DEBOUNCE - 1);
            cycle("cancel_no_dip", 1'b1, 1'b0);
        end
        sens.sa_raw = 1'b0;
        for (int k = 0; k < FALL_EDGE + 3; k++) cycle("cancel_drain", k < FALL_EDGE, 1'b0);
    endtask

    task automatic test_simultaneous();
        sens.sa_raw = 1'b1;
        sens.sb_raw = 1'b1;
        run_edges("simul_rise", 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        sens.sb_raw = 1'b0;
        run_edges("simul_b_drop", FALL_EDGE + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sens.sa_raw = 1'b0;
        run_edges("simul_a_drop", FALL_EDGE + 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        sens.sa_raw = 1'b1;
        sens.sb_raw = 1'b1;
        run_edges("areset_setup", 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sens.ta !== 1'b0 || sens.tb !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid_cycle: ta/tb got %b/%b, expected 0/0", sens.ta, sens.tb);
        end
        for (int k = 0; k < 3; k++) cycle("areset_hold", 1'b0, 1'b0);
        // Release between edges with inputs still high. The full latency starts over.
        reset = 1'b0;
        run_edges("areset_restart", 9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        sens.sa_raw = 1'b0;
        sens.sb_raw = 1'b0;
        run_edges("areset_drain", FALL_EDGE + 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef SENSOR_STRETCH_EN
    task automatic test_stretch_reentry();
        sens.sa_raw = 1'b1;
        for (int k = 0; k < 8; k++) cycle("reentry_setup", k >= RISE_EDGE, 1'b0);
        // Low for edges 0..9, which leaves the channel in HOLD. High again from edge 10.
        for (int k = 0; k < 20; k++) begin
            sens.sa_raw = (k >= 10);
            cycle("reentry_no_dip", 1'b1, 1'b0);
        end
        // The channel must have returned to ACTIVE, so a new drop takes the full stretch again.
        sens.sa_raw = 1'b0;
        for (int k = 0; k < FALL_EDGE + 3; k++) cycle("reentry_full_stretch", k < FALL_EDGE, 1'b0);
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_assert();
        test_deassert();
        test_glitch();
        test_cancel();
        test_simultaneous();
        test_async_reset();
`ifdef SENSOR_STRETCH_EN
        test_stretch_reentry();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
